// File: rtl/hit_judge.sv
// hit_judge: judges two-lane button presses against the hit row of the note
// window, keeps score/combo/lives and runs the IDLE/PLAY/OVER song flow.
module hit_judge #(
    parameter int SCORE_W = 16,
    parameter int COMBO_W = 8,
    parameter int LIVES   = 3
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [2:0]         mode,
    input  logic               scroll,
    input  logic [13:0]        window,
    input  logic [1:0]         btn,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [3:0]         lives,
    output logic               game_over,
    output logic [1:0]         hit,
    output logic [1:0]         miss
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    localparam logic [2:0]         MODE_LOAD  = 3'd3;
    localparam logic [2:0]         MODE_PLAY  = 3'd4;
    localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
    localparam logic [COMBO_W-1:0] COMBO_X2   = COMBO_W'(4);
    localparam logic [COMBO_W-1:0] COMBO_X4   = COMBO_W'(8);

    state_t             state, state_nxt;
    logic [1:0]         btn_q, credit, credit_nxt;
    logic [1:0]         press, row, good, bad, lost;
    logic [1:0]         n_hit, n_miss;
    logic [1:0]         shift;
    logic [3:0]         pts;
    logic [SCORE_W:0]   score_sum;
    logic [COMBO_W:0]   combo_sum;
    logic [SCORE_W-1:0] score_sat, score_nxt;
    logic [COMBO_W-1:0] combo_sat, combo_nxt;
    logic [3:0]         lives_dec, lives_nxt;
    logic [1:0]         hit_nxt, miss_nxt;

    // Per-lane judgement against the hit row (bit 6 of each 7-bit lane).
    assign press = btn & ~btn_q;
    assign row   = {window[13], window[6]};
    assign good  = press & row & ~credit;
    assign bad   = press & ~good;
    assign lost  = {2{scroll}} & row & ~credit & ~press;
    assign n_hit  = {1'b0, good[0]} + {1'b0, good[1]};
    assign n_miss = {1'b0, lost[0]} + {1'b0, lost[1]};

    // Multiplier chosen by the combo value held at the start of the cycle.
    assign shift = (combo < COMBO_X2) ? 2'd0 : (combo < COMBO_X4) ? 2'd1 : 2'd2;
    assign pts   = {2'b00, n_hit} << shift;

    assign score_sum = {1'b0, score} + (SCORE_W+1)'(pts);
    assign combo_sum = {1'b0, combo} + (COMBO_W+1)'(n_hit);
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign combo_sat = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    assign lives_dec = (lives > {2'b00, n_miss}) ? lives - {2'b00, n_miss} : 4'd0;

    // Next-state and next-register values for the song flow.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        state_nxt  = state;
        score_nxt  = score;
        combo_nxt  = combo;
        lives_nxt  = lives;
        credit_nxt = credit;
        hit_nxt    = 2'b00;
        miss_nxt   = 2'b00;
        if (mode == MODE_LOAD) begin
            // Song load wins in every state: fresh counters, back to IDLE.
            state_nxt  = IDLE;
            score_nxt  = '0;
            combo_nxt  = '0;
            lives_nxt  = LIVES_INIT;
            credit_nxt = 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (mode == MODE_PLAY) state_nxt = PLAY;
                end
                PLAY: begin
                    if (mode != MODE_PLAY) begin
                        state_nxt = IDLE;
                    end else begin
                        hit_nxt    = good;
                        miss_nxt   = lost;
                        score_nxt  = score_sat;
                        combo_nxt  = (|bad || |lost) ? '0 : combo_sat;
                        lives_nxt  = lives_dec;
                        // A scroll brings a new row, so it always wipes credit.
                        credit_nxt = scroll ? 2'b00 : (credit | good);
                        if (lives_dec == 4'd0) state_nxt = OVER;
                    end
                end
                OVER:    state_nxt = OVER;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Output, credit and button-history registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            score     <= '0;
            combo     <= '0;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
            hit       <= 2'b00;
            miss      <= 2'b00;
            credit    <= 2'b00;
            btn_q     <= 2'b00;
        end else begin
            score     <= score_nxt;
            combo     <= combo_nxt;
            lives     <= lives_nxt;
            game_over <= (state_nxt == OVER);
            hit       <= hit_nxt;
            miss      <= miss_nxt;
            credit    <= credit_nxt;
            btn_q     <= btn;
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed scenarios plus randomized play checked against a
// rule-level model of the judging and song flow.
module tb_hit_judge;

    logic        clk;
    logic        n_rst;
    logic [2:0]  mode;
    logic        scroll;
    logic [13:0] window;
    logic [1:0]  btn;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [3:0]  lives;
    logic        game_over;
    logic [1:0]  hit;
    logic [1:0]  miss;

    int checks = 0;
    int errors = 0;

    // Reference model state
    localparam int S_IDLE = 0, S_PLAY = 1, S_OVER = 2;
    int         m_state, m_score, m_combo, m_lives;
    logic [1:0] m_credit, m_btnq, m_hit, m_miss;

    hit_judge #(.SCORE_W(16), .COMBO_W(8), .LIVES(3)) dut (
        .clk(clk), .n_rst(n_rst), .mode(mode), .scroll(scroll), .window(window), .btn(btn),
        .score(score), .combo(combo), .lives(lives), .game_over(game_over), .hit(hit), .miss(miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advances the model by one clock using the rules of the game.
    task automatic model_update();
        logic [1:0] press;
        int nh, nm, mult;
        bit broke;
        if (!n_rst) begin
            m_state = S_IDLE; m_score = 0; m_combo = 0; m_lives = 3;
            m_credit = 0; m_btnq = 0; m_hit = 0; m_miss = 0;
            return;
        end
        press = btn & ~m_btnq;
        m_btnq = btn;
        m_hit = 0;
        m_miss = 0;
        if (mode == 3'd3) begin
            m_state = S_IDLE; m_score = 0; m_combo = 0; m_lives = 3; m_credit = 0;
        end else if (m_state == S_IDLE) begin
            if (mode == 3'd4) m_state = S_PLAY;
        end else if (m_state == S_PLAY) begin
            if (mode != 3'd4) begin
                m_state = S_IDLE;
            end else begin
                nh = 0; nm = 0; broke = 0;
                mult = (m_combo < 4) ? 1 : (m_combo < 8) ? 2 : 4;
                for (int i = 0; i < 2; i++) begin
                    if (press[i]) begin
                        if (window[7*i+6] && !m_credit[i]) begin
                            m_hit[i] = 1'b1; m_credit[i] = 1'b1; nh++;
                        end else begin
                            broke = 1;
                        end
                    end else if (scroll && window[7*i+6] && !m_credit[i]) begin
                        m_miss[i] = 1'b1; nm++;
                    end
                    if (scroll) m_credit[i] = 1'b0;
                end
                m_score = m_score + nh * mult;
                if (m_score > 65535) m_score = 65535;
                m_combo = (broke || nm > 0) ? 0 : m_combo + nh;
                if (m_combo > 255) m_combo = 255;
                m_lives = m_lives - nm;
                if (m_lives < 0) m_lives = 0;
                if (m_lives == 0) m_state = S_OVER;
            end
        end
    endtask

    // Drives one cycle of inputs; returns at the following falling edge.
    task automatic step(input logic r, input logic [2:0] m, input logic s,
                        input logic [13:0] w, input logic [1:0] b);
        n_rst = r; mode = m; scroll = s; window = w; btn = b;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b0, 3'd0, 1'b0, 14'h0000, 2'b00);
        checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score got=%0d want=0", score); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL reset_combo got=%0d want=0", combo); end
        checks++; if (lives !== 4'd3) begin errors++; $display("FAIL reset_lives got=%0d want=3", lives); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got=%b want=0", game_over); end
        checks++; if ({hit, miss} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got=%b want=0000", {hit, miss}); end
        step(1'b1, 3'd3, 1'b0, 14'h0000, 2'b00);
        step(1'b1, 3'd4, 1'b0, 14'h0000, 2'b00);
        checks++; if ({lives, game_over} !== {4'd3, 1'b0}) begin errors++; $display("FAIL start_play lives/go got=%0d/%b want=3/0", lives, game_over); end
    endtask

    task automatic test_hit_bad();
        step(1'b1, 3'd4, 1'b0, 14'h0040, 2'b01);
        checks++; if (hit !== 2'b01) begin errors++; $display("FAIL first_hit hit got=%b want=01", hit); end
        checks++; if ({score, combo} !== {16'd1, 8'd1}) begin errors++; $display("FAIL first_hit score/combo got=%0d/%0d want=1/1", score, combo); end
        step(1'b1, 3'd4, 1'b0, 14'h0040, 2'b00);
        checks++; if (hit !== 2'b00) begin errors++; $display("FAIL hit_one_cycle got=%b want=00", hit); end
        step(1'b1, 3'd4, 1'b0, 14'h0040, 2'b01);
        checks++; if ({score, combo, hit, lives} !== {16'd1, 8'd0, 2'b00, 4'd3}) begin
            errors++; $display("FAIL bad_press score/combo/hit/lives got=%0d/%0d/%b/%0d want=1/0/00/3", score, combo, hit, lives);
        end
    endtask

    task automatic test_dual_hit();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3'd4, 1'b1, 14'h0040, 2'b00);
            step(1'b1, 3'd4, 1'b0, 14'h0040, 2'b01);
        end
        checks++; if ({score, combo} !== {16'd5, 8'd4}) begin errors++; $display("FAIL build_combo score/combo got=%0d/%0d want=5/4", score, combo); end
        step(1'b1, 3'd4, 1'b1, 14'h0040, 2'b00);
        checks++; if (miss !== 2'b00) begin errors++; $display("FAIL credited_scroll miss got=%b want=00", miss); end
        step(1'b1, 3'd4, 1'b0, 14'h2040, 2'b11);
        checks++; if (hit !== 2'b11) begin errors++; $display("FAIL dual_hit hit got=%b want=11", hit); end
        checks++; if ({score, combo} !== {16'd9, 8'd6}) begin errors++; $display("FAIL dual_hit score/combo got=%0d/%0d want=9/6", score, combo); end
        step(1'b1, 3'd4, 1'b1, 14'h2040, 2'b00);
    endtask

    task automatic test_miss_over();
        step(1'b1, 3'd4, 1'b1, 14'h2000, 2'b00);
        checks++; if ({miss, lives, combo} !== {2'b10, 4'd2, 8'd0}) begin
            errors++; $display("FAIL miss_lane1 miss/lives/combo got=%b/%0d/%0d want=10/2/0", miss, lives, combo);
        end
        step(1'b1, 3'd4, 1'b1, 14'h0040, 2'b00);
        checks++; if ({miss, lives, game_over} !== {2'b01, 4'd1, 1'b0}) begin
            errors++; $display("FAIL miss_lane0 miss/lives/go got=%b/%0d/%b want=01/1/0", miss, lives, game_over);
        end
        step(1'b1, 3'd4, 1'b1, 14'h2040, 2'b00);
        checks++; if ({miss, lives, game_over} !== {2'b11, 4'd0, 1'b1}) begin
            errors++; $display("FAIL lives_clamp miss/lives/go got=%b/%0d/%b want=11/0/1", miss, lives, game_over);
        end
        step(1'b1, 3'd4, 1'b0, 14'h2040, 2'b01);
        checks++; if ({hit, score} !== {2'b00, 16'd9}) begin errors++; $display("FAIL over_press hit/score got=%b/%0d want=00/9", hit, score); end
        step(1'b1, 3'd4, 1'b1, 14'h2040, 2'b00);
        checks++; if ({miss, lives, game_over} !== {2'b00, 4'd0, 1'b1}) begin
            errors++; $display("FAIL over_scroll miss/lives/go got=%b/%0d/%b want=00/0/1", miss, lives, game_over);
        end
        step(1'b1, 3'd3, 1'b0, 14'h0000, 2'b00);
        checks++; if ({score, combo, lives, game_over} !== {16'd0, 8'd0, 4'd3, 1'b0}) begin
            errors++; $display("FAIL reload score/combo/lives/go got=%0d/%0d/%0d/%b want=0/0/3/0", score, combo, lives, game_over);
        end
    endtask

    task automatic test_press_scroll();
        step(1'b1, 3'd4, 1'b0, 14'h0000, 2'b00);
        step(1'b1, 3'd4, 1'b1, 14'h0040, 2'b01);
        checks++; if ({hit, miss, lives} !== {2'b01, 2'b00, 4'd3}) begin
            errors++; $display("FAIL press_scroll hit/miss/lives got=%b/%b/%0d want=01/00/3", hit, miss, lives);
        end
        checks++; if ({score, combo} !== {16'd1, 8'd1}) begin errors++; $display("FAIL press_scroll score/combo got=%0d/%0d want=1/1", score, combo); end
    endtask

    task automatic test_held_btn_and_reset();
        step(1'b1, 3'd3, 1'b0, 14'h2040, 2'b11);
        step(1'b1, 3'd4, 1'b0, 14'h2040, 2'b11);
        step(1'b1, 3'd4, 1'b0, 14'h2040, 2'b11);
        checks++; if ({hit, score} !== {2'b00, 16'd0}) begin errors++; $display("FAIL held_entry hit/score got=%b/%0d want=00/0", hit, score); end
        step(1'b1, 3'd4, 1'b0, 14'h2040, 2'b00);
        step(1'b1, 3'd4, 1'b0, 14'h2040, 2'b01);
        step(1'b1, 3'd4, 1'b0, 14'h2040, 2'b01);
        checks++; if ({combo, score, hit} !== {8'd1, 16'd1, 2'b00}) begin
            errors++; $display("FAIL held_no_bad combo/score/hit got=%0d/%0d/%b want=1/1/00", combo, score, hit);
        end
        step(1'b0, 3'd4, 1'b1, 14'h2040, 2'b11);
        checks++; if ({score, combo, lives, game_over, hit, miss} !== {16'd0, 8'd0, 4'd3, 1'b0, 2'b00, 2'b00}) begin
            errors++; $display("FAIL mid_reset score/combo/lives/go/hit/miss got=%0d/%0d/%0d/%b/%b/%b want=0/0/3/0/00/00",
                               score, combo, lives, game_over, hit, miss);
        end
    endtask

    task automatic test_random();
        logic [13:0] w;
        logic [2:0]  m;
        int          r;
        for (int c = 0; c < 600; c++) begin
            w = 14'($urandom);
            w[6]  = ($urandom_range(0, 3) != 0);
            w[13] = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            if (r < 16)      m = 3'd4;
            else if (r < 18) m = 3'd3;
            else             m = 3'($urandom_range(5, 10));
            step(($urandom_range(0, 63) != 0), m, ($urandom_range(0, 3) == 0), w, 2'($urandom_range(0, 3)));
            checks++; if (score !== 16'(m_score)) begin errors++; $display("FAIL rand_score cyc=%0d got=%0d want=%0d", c, score, m_score); end
            checks++; if (combo !== 8'(m_combo)) begin errors++; $display("FAIL rand_combo cyc=%0d got=%0d want=%0d", c, combo, m_combo); end
            checks++; if (lives !== 4'(m_lives)) begin errors++; $display("FAIL rand_lives cyc=%0d got=%0d want=%0d", c, lives, m_lives); end
            checks++; if (game_over !== (m_state == S_OVER)) begin errors++; $display("FAIL rand_game_over cyc=%0d got=%b want=%b", c, game_over, m_state == S_OVER); end
            checks++; if (hit !== m_hit) begin errors++; $display("FAIL rand_hit cyc=%0d got=%b want=%b", c, hit, m_hit); end
            checks++; if (miss !== m_miss) begin errors++; $display("FAIL rand_miss cyc=%0d got=%b want=%b", c, miss, m_miss); end
        end
    endtask

    initial begin
        n_rst = 1'b0; mode = 3'd0; scroll = 1'b0; window = 14'h0000; btn = 2'b00;
        test_reset();
        test_hit_bad();
        test_dual_hit();
        test_miss_over();
        test_press_scroll();
        test_held_btn_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
